// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 slave among NUM_MASTERS masters, granting per CYC envelope.
// Optional slave-hang watchdog enabled with `define WB_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_ni,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    output logic [DATA_WIDTH-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic [NUM_MASTERS-1:0]                m_stall_o,
    output logic [ADDR_WIDTH-1:0]                 s_adr_o,
    output logic [DATA_WIDTH-1:0]                 s_dat_o,
    output logic [DATA_WIDTH/8-1:0]               s_sel_o,
    output logic                                  s_we_o,
    output logic                                  s_stb_o,
    output logic                                  s_cyc_o,
    input  logic [DATA_WIDTH-1:0]                 s_dat_i,
    input  logic                                  s_ack_i,
    input  logic                                  s_err_i,
    input  logic                                  s_stall_i,
    output logic [NUM_MASTERS-1:0]                grant_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(NUM_MASTERS);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W:0]         sum;
    logic                   any_req;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   timeout;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    assign timeout = (state_q == GRANT) && (to_cnt_q == TO_LIM);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == IDLE || s_ack_i || s_err_i) begin
            to_cnt_d = '0;
        end else if (owner_stb && !timeout) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // First requester found walking upward from the slot after the last winner
    always_comb begin
        winner  = last_q;
        any_req = 1'b0;
        sum     = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            sum = {1'b0, last_q} + (IDX_W + 1)'(k);
            if (sum >= N_L) begin
                sum = sum - N_L;
            end
            if (!any_req && m_cyc_i[sum[IDX_W-1:0]]) begin
                any_req = 1'b1;
                winner  = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        if (state_q == GRANT) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_q[i]) begin
                    owner_cyc    = m_cyc_i[i];
                    owner_stb    = m_stb_i[i];
                    s_adr_o      = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    s_dat_o      = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                    s_sel_o      = m_sel_i[i*SEL_W +: SEL_W];
                    s_we_o       = m_we_i[i];
                    s_cyc_o      = m_cyc_i[i] & ~timeout;
                    s_stb_o      = m_stb_i[i] & ~timeout;
                    // Responses are dropped once the owner has let go of CYC
                    m_ack_o[i]   = s_ack_i & m_cyc_i[i] & ~timeout;
                    m_err_o[i]   = (s_err_i & m_cyc_i[i]) | timeout;
                    m_stall_o[i] = s_stall_i;
                end
            end
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d         = GRANT;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    last_d          = winner;
                end
            end
            GRANT: begin
                if (!owner_cyc || timeout) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IDX_W'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] m_adr;
    logic [63:0] m_dat;
    logic [7:0]  m_sel;
    logic [1:0]  m_we, m_stb, m_cyc;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o, m_stall_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_stall_i;
    logic [1:0]  grant_o;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_cyc   = 2'b00;
        m_stb   = 2'b00;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_stall_i = 1'b0;
        s_dat_i = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic        stl;
        logic [31:0] sdat;
        logic [1:0]  e_gnt;
        logic        e_scyc;
        logic        e_sstb;
        logic [31:0] e_sadr;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
        logic [1:0]  e_stall;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [1:0] eg;
        int         expm;
        int         w;
        logic       bad;

        //           cyc    stb    ack   err   stl   sdat          gnt   scyc  sstb  sadr        ack    err    stall
        vt[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b11};
        vt[1]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b11};
        vt[2]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0,        2'b01, 1'b1, 1'b1, 32'h10, 2'b00, 2'b00, 2'b11};
        vt[3]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 32'hAAAA0003, 2'b01, 1'b1, 1'b1, 32'h10, 2'b01, 2'b00, 2'b10};
        vt[4]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00, 2'b10};
        vt[5]  = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b11};
        vt[6]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b1, 32'h20, 2'b00, 2'b00, 2'b01};
        vt[7]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 32'hBEEF0004, 2'b10, 1'b1, 1'b1, 32'h20, 2'b10, 2'b00, 2'b01};
        vt[8]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b1, 32'h20, 2'b00, 2'b00, 2'b01};
        vt[9]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 32'h12345678, 2'b10, 1'b1, 1'b1, 32'h20, 2'b10, 2'b00, 2'b01};
        vt[10] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0,        2'b10, 1'b0, 1'b0, 32'h20, 2'b00, 2'b00, 2'b01};
        vt[11] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b11};
        vt[12] = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 1'b1, 32'h10, 2'b00, 2'b01, 2'b10};
        vt[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        2'b01, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00, 2'b10};
        vt[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 2'b11};

        m_adr = {32'h20, 32'h10};
        m_dat = {32'h5A5A0002, 32'hA5A50001};
        m_sel = {4'h3, 4'hF};
        m_we  = 2'b01;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        s_dat_i = 32'h0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_stall_i = 1'b0;

        #2;
        chk("rst_grant", 64'(grant_o), 64'(2'b00));
        chk("rst_scyc", 64'(s_cyc_o), 64'(1'b0));
        chk("rst_stb_we", 64'({s_stb_o, s_we_o}), 64'(2'b00));
        chk("rst_ack_err", 64'({m_ack_o, m_err_o}), 64'(4'b0000));
        chk("rst_stall", 64'(m_stall_o), 64'(2'b11));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < 15; r++) begin
            m_cyc     = vt[r].cyc;
            m_stb     = vt[r].stb;
            s_ack_i   = vt[r].ack;
            s_err_i   = vt[r].err;
            s_stall_i = vt[r].stl;
            s_dat_i   = vt[r].sdat;
            #2;
            chk($sformatf("v%0d_grant", r), 64'(grant_o), 64'(vt[r].e_gnt));
            chk($sformatf("v%0d_scyc", r), 64'(s_cyc_o), 64'(vt[r].e_scyc));
            chk($sformatf("v%0d_sstb", r), 64'(s_stb_o), 64'(vt[r].e_sstb));
            chk($sformatf("v%0d_ack", r), 64'(m_ack_o), 64'(vt[r].e_ack));
            chk($sformatf("v%0d_err", r), 64'(m_err_o), 64'(vt[r].e_err));
            chk($sformatf("v%0d_stall", r), 64'(m_stall_o), 64'(vt[r].e_stall));
            chk($sformatf("v%0d_mdat", r), 64'(m_dat_o), 64'(vt[r].sdat));
            if (vt[r].e_gnt != 2'b00) begin
                chk($sformatf("v%0d_sadr", r), 64'(s_adr_o), 64'(vt[r].e_sadr));
                chk($sformatf("v%0d_swe", r), 64'(s_we_o), 64'(vt[r].e_gnt == 2'b01));
                chk($sformatf("v%0d_sdat", r), 64'(s_dat_o),
                    (vt[r].e_gnt == 2'b01) ? 64'h A5A50001 : 64'h5A5A0002);
                chk($sformatf("v%0d_ssel", r), 64'(s_sel_o),
                    (vt[r].e_gnt == 2'b01) ? 64'hF : 64'h3);
            end
            @(posedge clk);
            #1;
        end

        // Fairness: both masters keep requesting, one transfer per CYC envelope
        do_reset();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        expm  = 0;
        for (int n = 0; n < 8; n++) begin
            w = 0;
            while (grant_o == 2'b00 && w < 5) begin
                tick();
                w++;
            end
            eg = (expm == 0) ? 2'b01 : 2'b10;
            chk($sformatf("fair%0d_grant", n), 64'(grant_o), 64'(eg));
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("fair%0d_ack", n), 64'(m_ack_o), 64'(eg));
            tick();
            s_ack_i = 1'b0;
            m_cyc[expm] = 1'b0;
            m_stb[expm] = 1'b0;
            tick();
            m_cyc = 2'b11;
            m_stb = 2'b11;
            expm  = 1 - expm;
        end

        // Locked burst: master 1 keeps CYC over three reads while master 0 waits
        do_reset();
        m_we  = 2'b00;
        m_cyc = 2'b10;
        m_stb = 2'b10;
        m_adr[63:32] = 32'h0;
        tick();
        chk("burst_grant", 64'(grant_o), 64'(2'b10));
        m_cyc = 2'b11;
        m_stb = 2'b11;
        for (int k = 0; k < 3; k++) begin
            m_adr[63:32] = 32'(4 * k);
            s_dat_i = 32'hD0000000 + 32'(k);
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("burst%0d_sadr", k), 64'(s_adr_o), 64'(4 * k));
            chk($sformatf("burst%0d_mdat", k), 64'(m_dat_o), 64'(32'hD0000000 + 32'(k)));
            chk($sformatf("burst%0d_ack", k), 64'(m_ack_o), 64'(2'b10));
            chk($sformatf("burst%0d_grant", k), 64'(grant_o), 64'(2'b10));
            tick();
        end
        s_ack_i = 1'b0;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        #1;
        chk("burst_rel_scyc", 64'(s_cyc_o), 64'(1'b0));
        tick();
        chk("burst_idle_gap", 64'(grant_o), 64'(2'b00));
        tick();
        chk("burst_next_owner", 64'(grant_o), 64'(2'b01));

        // Reset while master 1 owns the bus with STB high
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        tick();
        chk("midrst_pre_grant", 64'(grant_o), 64'(2'b10));
        chk("midrst_pre_stb", 64'(s_stb_o), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_scyc", 64'(s_cyc_o), 64'(1'b0));
        chk("midrst_grant", 64'(grant_o), 64'(2'b00));
        chk("midrst_stall", 64'(m_stall_o), 64'(2'b11));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        chk("midrst_restart_m0", 64'(grant_o), 64'(2'b01));

        // Hung slave
        do_reset();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("to%0d_err", i), 64'(m_err_o), (i == 8) ? 64'(2'b01) : 64'(2'b00));
            if (i == 8) begin
                chk("to_scyc_forced", 64'(s_cyc_o), 64'(1'b0));
            end
            tick();
        end
        chk("to_idle", 64'(grant_o), 64'(2'b00));
`else
        bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (grant_o !== 2'b01 || m_err_o !== 2'b00 || s_cyc_o !== 1'b1) begin
                bad = 1'b1;
            end
            tick();
        end
        chk("hung_hold", 64'(bad), 64'(1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone B4 slave port (typically a register-bus slave adapter) between NUM_MASTERS Wishbone masters.
- Grants bus ownership per CYC envelope and muxes address/data/control to the slave.
- Routes ACK/ERR/read data back to the owner only; non-owners are stalled.
- Sits between masters (CPU, DMA, debug bridge) and a single peripheral slave.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; SEL width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with WB_ARB_TIMEOUT_EN).

Ports:
wb_clk_i  in  1  bus clock
wb_rst_ni  in  1  asynchronous active-low reset
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses, master i at slice i
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data
m_sel_i  in  NUM_MASTERS*(DATA_WIDTH/8)  master byte selects
m_we_i  in  NUM_MASTERS  master write enables
m_stb_i  in  NUM_MASTERS  master strobes
m_cyc_i  in  NUM_MASTERS  master cycle requests
m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ACK
m_err_o  out  NUM_MASTERS  per-master ERR
m_stall_o  out  NUM_MASTERS  per-master STALL
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_sel_o  out  DATA_WIDTH/8  slave byte selects
s_we_o  out  1  slave write enable
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_dat_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave ACK
s_err_i  in  1  slave ERR
s_stall_i  in  1  slave STALL
grant_o  out  NUM_MASTERS  one-hot current owner (debug/status)

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_ni is asynchronous, active-low.
- Reset values:
  - State IDLE; grant_o = 0; round-robin pointer last = NUM_MASTERS-1, so master 0 has first priority.
  - s_cyc_o = s_stb_o = s_we_o = 0; m_ack_o = m_err_o = 0; m_stall_o = all ones.
  - Reset asserted mid-transaction aborts immediately; slave sees CYC drop asynchronously.
- FSM IDLE:
  - If any m_cyc_i is high, select the first requester searching last+1, last+2, ... (mod NUM_MASTERS).
  - Register grant_o at the next edge and move to GRANT; last is updated to the winner.
  - Arbitration latency is 1 cycle from CYC to grant.
  - No requests: remain in IDLE, outputs stay at reset values.
- FSM GRANT (owner g):
  - Slave outputs combinationally follow master g: s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g], plus adr/dat/sel/we.
  - m_ack_o[g] = s_ack_i, m_err_o[g] = s_err_i, m_stall_o[g] = s_stall_i.
  - All other masters: ack = err = 0, stall = 1.
  - m_dat_o = s_dat_i at all times.
- Release:
  - When m_cyc_i[g] is sampled low, return to IDLE at that edge; grant_o clears.
  - s_cyc_o is already low combinationally that cycle.
  - Next arbitration happens from IDLE, so there is a minimum 1 idle cycle between owners.
- Bus locking: the grant is held across multiple STB phases while CYC stays high (pipelined/block transfers).
- Simultaneous requests: round-robin order only; no fixed priority after reset.
- Withdrawn request: a master dropping CYC in IDLE before being granted loses nothing; it is not granted.
- Late responses: s_ack_i/s_err_i arriving after the owner dropped CYC are discarded (no master sees them).
- Other bits of grant_o never assert; grant_o is always one-hot or zero.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on grant and on every s_ack_i/s_err_i, and increments while s_stb_o is high with no response.
  - On reaching TIMEOUT_CYCLES, assert m_err_o[g] for exactly one cycle.
  - In that cycle, force s_cyc_o/s_stb_o low; the FSM goes to IDLE on the following edge regardless of m_cyc_i[g].
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- When undefined: no counter; a hung slave holds the grant indefinitely.

Test Plan:
- Reset, single request: reset, then m_cyc_i=01, m_stb_i=01 write adr 0x10 data 0xA5A5_0001 -> grant_o=01 one cycle later; s_adr_o=0x10; slave ACK appears on m_ack_o[0] only; m_stall_o[1]=1.
- Simultaneous requests: m_cyc_i=11 from IDLE after reset -> master 0 granted first; after it drops CYC, one idle cycle, then master 1 granted.
- Fairness: both masters continuously request 4 single transfers each -> grant order strictly 0,1,0,1,... with no master served twice in a row.
- Locked burst: master 1 holds CYC across 3 STB reads of 0x0,0x4,0x8 while master 0 requests -> master 1 keeps grant until CYC drops; m_dat_o matches slave data; master 0 sees no ACK.
- Reset mid-transfer: wb_rst_ni low while grant_o=10, s_stb_o=1 -> s_cyc_o=0 and grant_o=0 immediately; after release, pointer restarts with master 0 priority.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never ACKs -> m_err_o[g] pulses 1 cycle after 8 cycles of pending STB, then FSM returns to IDLE; without the macro, grant is held for 100+ cycles.
